// File: rtl/simpleuart_pkg.sv
// Shared definitions for the simple UART transmit FIFO.
// Holds the data-path widths and the occupancy helper used by the FIFO top.
package simpleuart_pkg;

  localparam int UART_DAT_W = 32;
  localparam int BYTE_W     = 8;
  // Widest pointer supported (DEPTH_LOG2 up to 8 plus the wrap bit).
  localparam int PTR_MAX_W  = 9;

  // Occupancy from wrap-bit pointers. Callers zero-extend narrower pointers
  // and truncate the result back to their own pointer width; the modulo
  // arithmetic survives that truncation.
  function automatic logic [PTR_MAX_W-1:0] fifo_level(
    input logic [PTR_MAX_W-1:0] wptr,
    input logic [PTR_MAX_W-1:0] rptr
  );
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/simpleuart_fifo_mem.sv
// Byte storage for the transmit FIFO: 2**DEPTH_LOG2 x 8 register array with
// synchronous write and asynchronous (combinational) read. Not reset.
// Ports:
//   clk   - system clock
//   we    - write enable, stores wdata at waddr on the rising edge
//   waddr - write slot
//   wdata - byte to store
//   raddr - read slot
//   rdata - byte currently held at raddr
module simpleuart_fifo_mem
  import simpleuart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [BYTE_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [BYTE_W-1:0]     rdata
);

  logic [BYTE_W-1:0] mem_r [2**DEPTH_LOG2];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/simpleuart_txfifo.sv
// Transmit byte FIFO placed in front of the simple UART data register.
// The CPU pushes bytes without stalling; the FIFO drains them into the UART
// using its we/wait handshake and reports level, overflow and low-watermark.
// Ports:
//   clk, resetn    - clock, asynchronous active-low reset
//   wr_en, wr_data - push a byte (dropped and flagged in ovf when full)
//   flush          - discard everything queued, including a same-cycle push
//   clr_ovf        - clear the sticky overflow flag
//   level/full/empty/irq_lowater - occupancy status (from registered pointers)
//   ovf            - sticky dropped-push flag
//   uart_dat_we/uart_dat_di/uart_dat_wait - UART data-register handshake
module simpleuart_txfifo
  import simpleuart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int LOWATER    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic                  flush,
  input  logic                  clr_ovf,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf,
  output logic                  irq_lowater,
  output logic                  uart_dat_we,
  output logic [UART_DAT_W-1:0] uart_dat_di,
  input  logic                  uart_dat_wait
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_L   = PW'(2**DEPTH_LOG2);
  localparam logic [PW-1:0] LOWATER_L = PW'(LOWATER);

  logic [PW-1:0]     wptr_r;
  logic [PW-1:0]     rptr_r;
  logic [PW-1:0]     wptr_next;
  logic [PW-1:0]     rptr_next;
  logic              ovf_r;
  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] rd_data;

  // Status derives only from the registered pointers, so nothing here
  // depends on uart_dat_wait (the UART builds wait from we).
  assign level       = PW'(fifo_level(PTR_MAX_W'(wptr_r), PTR_MAX_W'(rptr_r)));
  assign full        = (level == DEPTH_L);
  assign empty       = (level == {PW{1'b0}});
  assign irq_lowater = (level <= LOWATER_L);
  assign ovf         = ovf_r;

  assign uart_dat_we = !empty;
  assign uart_dat_di = empty ? {UART_DAT_W{1'b0}}
                             : {{(UART_DAT_W-BYTE_W){1'b0}}, rd_data};

  // Full is judged on the current level, so a same-cycle pop never frees a
  // slot for the push.
  assign push = wr_en && !full;
  assign pop  = uart_dat_we && !uart_dat_wait;

  // Next pointers; flush snaps rptr onto the post-push wptr so a push in the
  // flush cycle is discarded too.
  always_comb begin
    wptr_next = wptr_r + PW'(push);
    rptr_next = rptr_r + PW'(pop);
    if (flush) begin
      rptr_next = wptr_next;
    end else begin
      rptr_next = rptr_r + PW'(pop);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
    end else begin
      wptr_r <= wptr_next;
      rptr_r <= rptr_next;
    end
  end

  // Sticky overflow: a rejected push wins over a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_r <= 1'b0;
    end else if (wr_en && full) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  simpleuart_fifo_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wptr_r[DEPTH_LOG2-1:0]),
    .wdata(wr_data),
    .raddr(rptr_r[DEPTH_LOG2-1:0]),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_simpleuart_txfifo.sv
// Self-checking bench for simpleuart_txfifo: a queue model checked every
// cycle plus directed, hand-computed expectations.
module tb_simpleuart_txfifo;

  logic        clk;
  logic        resetn;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        flush;
  logic        clr_ovf;
  logic [4:0]  level;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        irq_lowater;
  logic        uart_dat_we;
  logic [31:0] uart_dat_di;
  logic        uart_dat_wait;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit saw_aa   = 1'b0;

  // Model state: the queued bytes and the sticky flag.
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;

  simpleuart_txfifo dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .clr_ovf      (clr_ovf),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .ovf          (ovf),
    .irq_lowater  (irq_lowater),
    .uart_dat_we  (uart_dat_we),
    .uart_dat_di  (uart_dat_di),
    .uart_dat_wait(uart_dat_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO as a queue of bytes, depth 16.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      bit was_full;
      was_full = (q.size() == 16);
      if (q.size() > 0 && !uart_dat_wait) void'(q.pop_front());
      if (wr_en && !was_full) q.push_back(wr_data);
      if (flush) q.delete();
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int n;
      n = q.size();
      chk("level", 32'(level), 32'(n));
      chk("full", 32'(full), 32'(n == 16));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("irq_lowater", 32'(irq_lowater), 32'(n <= 2));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("uart_dat_we", 32'(uart_dat_we), 32'(n != 0));
      chk("uart_dat_di", uart_dat_di, (n != 0) ? {24'h0, q[0]} : 32'h0);
      if (uart_dat_we && uart_dat_di == 32'h0000_00AA) saw_aa = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    resetn = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    flush = 1'b0;
    clr_ovf = 1'b0;
    uart_dat_wait = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk_en = 1'b1;
    // Outputs during reset.
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_irq", 32'(irq_lowater), 32'd1);
    chk("rst_we", 32'(uart_dat_we), 32'd0);
    chk("rst_di", uart_dat_di, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // 1: single byte with 1-cycle latency, popped at next edge.
    push(8'h41);
    chk("t1_we", 32'(uart_dat_we), 32'd1);
    chk("t1_di", uart_dat_di, 32'h41);
    tick();
    chk("t1_empty", 32'(empty), 32'd1);

    // 2: fill to full with wait held, overflow, then ordered drain.
    uart_dat_wait = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_level", 32'(level), 32'd16);
    chk("t2_irq", 32'(irq_lowater), 32'd0);
    push(8'h99);
    chk("t2_ovf", 32'(ovf), 32'd1);
    chk("t2_level17", 32'(level), 32'd16);
    uart_dat_wait = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", uart_dat_di, 32'(i));
      tick();
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: level 5, pushes every cycle with wait toggling, then free-running.
    uart_dat_wait = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    chk("t3_level5", 32'(level), 32'd5);
    for (int i = 0; i < 40; i++) begin
      uart_dat_wait = (i < 20) ? ((i % 2) == 0) : 1'b0;
      push(8'h50 + 8'(i));
      if (i == 19) chk("t3_level20", 32'(level), 32'd15);
    end
    chk("t3_level40", 32'(level), 32'd15);

    // 4: drain to 10, then flush together with a push of 8'hAA.
    for (int i = 0; i < 5; i++) tick();
    chk("t4_level10", 32'(level), 32'd10);
    uart_dat_wait = 1'b1;
    flush = 1'b1;
    push(8'hAA);
    flush = 1'b0;
    chk("t4_level0", 32'(level), 32'd0);
    uart_dat_wait = 1'b0;
    tick();
    tick();
    chk("t4_no_aa", 32'(saw_aa), 32'd0);

    // 5: overflow with simultaneous pop, and set-vs-clear priority.
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t5_ovf_clr0", 32'(ovf), 32'd0);
    uart_dat_wait = 1'b1;
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
    uart_dat_wait = 1'b0;
    push(8'h77);
    chk("t5_ovf", 32'(ovf), 32'd1);
    chk("t5_level15", 32'(level), 32'd15);
    uart_dat_wait = 1'b1;
    push(8'h78);
    chk("t5_refull", 32'(level), 32'd16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t5_ovf_cleared", 32'(ovf), 32'd0);
    clr_ovf = 1'b1;
    push(8'h79);
    clr_ovf = 1'b0;
    chk("t5_ovf_setwins", 32'(ovf), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t5_ovf_clr", 32'(ovf), 32'd0);

    // 6: ovf set, flush keeps it; async reset mid-drain at level 7.
    push(8'h7A);
    chk("t6_ovf_set", 32'(ovf), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_ovf", 32'(ovf), 32'd1);
    chk("t6_flush_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 7; i++) push(8'hE0 + 8'(i));
    chk("t6_level7", 32'(level), 32'd7);
    uart_dat_wait = 1'b0;
    #1;
    chk("t6_we_before", 32'(uart_dat_we), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t6_we_async", 32'(uart_dat_we), 32'd0);
    chk("t6_di_async", uart_dat_di, 32'h0);
    chk("t6_level_async", 32'(level), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_ovf", 32'(ovf), 32'd0);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/simpleuart_txfifo.md
Name: simpleuart_txfifo

Overview:
Transmit byte FIFO that sits directly upstream of the simple UART's data register. The CPU-side bus pushes bytes without stalling. The block drains them into the UART's transmit data port using the UART's `we`/`wait` handshake. It adds level, overflow and low-watermark status so firmware can post bursts and take an interrupt instead of polling.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 bytes); legal range 1..8.
- LOWATER, 2, `irq_lowater` is asserted while level <= LOWATER; must be < 2**DEPTH_LOG2.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- wr_en  in  1  push `wr_data` this cycle
- wr_data  in  8  byte to enqueue
- flush  in  1  synchronous discard of all queued bytes
- clr_ovf  in  1  clear the `ovf` sticky flag
- level  out  DEPTH_LOG2+1  number of queued bytes
- full  out  1  level == 2**DEPTH_LOG2
- empty  out  1  level == 0
- ovf  out  1  sticky: a push was dropped because the FIFO was full
- irq_lowater  out  1  level <= LOWATER
- uart_dat_we  out  1  to the UART data-register write enable
- uart_dat_di  out  32  to the UART data-register write data
- uart_dat_wait  in  1  from the UART; high means the write is not taken this cycle

Behaviour:
- Reset (async, `resetn` low): read and write pointers = 0, `ovf` = 0.
  - Outputs during reset: level=0, empty=1, full=0, irq_lowater=1, uart_dat_we=0, uart_dat_di=32'h0.
  - Storage array is not reset.
- Pointers are DEPTH_LOG2+1 bits; the MSB is the wrap bit.
  - level = wptr - rptr (modulo 2**(DEPTH_LOG2+1)).
  - full/empty/level/irq_lowater are combinational from registered pointers only.
- Drain side:
  - `uart_dat_we` = !empty.
  - `uart_dat_di` = {24'h0, mem[rptr low bits]}; 32'h0 when empty.
  - Neither output may depend combinationally on `uart_dat_wait`, because the UART derives `wait` from `we`.
  - Pop occurs at a clock edge where uart_dat_we && !uart_dat_wait; rptr increments by 1.
  - At most one pop per cycle.
  - Data must be held stable while `wait` is high.
- Fill side:
  - Push occurs when wr_en && !full: mem[wptr] <= wr_data, wptr increments.
  - `full` is evaluated on the current level. A push while full is rejected even if a pop happens in the same cycle. A rejected push sets `ovf`.
  - Push and pop in the same cycle (not full, not empty): level unchanged.
  - Push into empty: the byte appears on `uart_dat_di` the following cycle (1-cycle write-to-drain latency). There is no bypass.
- `flush`:
  - Sets rptr <= wptr's post-push value: any push in the same cycle is also discarded, and the FIFO is empty next cycle.
  - Has priority over push and pop pointer updates.
  - A byte the UART accepts in the flush cycle is considered sent.
  - Does not touch `ovf`.
- `ovf`:
  - Set has priority over `clr_ovf` in the same cycle.
  - A rejected push while `flush` is high still sets `ovf`.
- Wrap-around: pointers roll over naturally. Full at depth 2**DEPTH_LOG2 must be reachable; all slots are usable.
- The UART's own dummy/busy period after a divider write simply shows up as `wait` = 1. No special handling.

Decomposition:
- Shared package `simpleuart_pkg`:
  - UART_DAT_W=32, BYTE_W=8
  - function fifo_level(wptr, rptr)
- One natural sub-module: `simpleuart_fifo_mem`, a 2**DEPTH_LOG2 x 8 register array with synchronous write and asynchronous read. Pointer/flag logic stays in the top.

Test Plan:
1. Reset, then push 8'h41 with `uart_dat_wait`=0 → next cycle uart_dat_we=1, uart_dat_di=32'h41; popped at that edge; empty=1 after.
2. Hold wait=1 and push 16 bytes 8'h00..8'h0F → full=1, level=16, irq_lowater=0. A 17th push sets ovf=1 and level stays 16. Release wait → bytes emerge in order 00..0F and empty returns.
3. Level at 5 and `wait` toggling every other cycle; push each cycle → level unchanged on push+pop cycles, +1 on push-only cycles. No byte is lost or duplicated across 40 pushes with pointer wrap.
4. Level 10, assert flush together with wr_en (data 8'hAA) → level=0 next cycle and 8'hAA never appears on uart_dat_di.
5. Full FIFO with a pop and a push in the same cycle → push rejected, ovf=1, level=15. clr_ovf together with a rejected push → ovf remains 1. clr_ovf alone → ovf=0.
6. Assert resetn low asynchronously mid-drain at level 7 → uart_dat_we drops without a clock edge; after release, empty=1 and ovf=0.
